// File: rtl/baud_gen_frac.sv
// Fractional baud tick generator producing oversample, bit-rate and mid-bit ticks.
// Define BAUD_FRAC_EN to build the fractional accumulator; otherwise the period is div_int_q only.
module baud_gen_frac #(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEF_DIV_INT  = 13,
  parameter int DEF_DIV_FRAC = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              restart,
  output logic              tick_os,
  output logic              tick_bit,
  output logic              tick_mid,
  output logic              cfg_err
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0] div_int_q;
  logic [DIV_W-1:0] cnt;
  logic [OS_W-1:0]  os_cnt;
  logic             div_ok;
  logic [DIV_W-1:0] div_sel;
  logic             carry;

  // Divisors of 0 or 1 cannot form a valid countdown, so they are rejected.
  assign div_ok  = (div_int >= DIV_W'(2));
  assign div_sel = (div_load && div_ok) ? div_int : div_int_q;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] div_frac_q;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, div_frac_q};
  assign carry   = acc_sum[FRAC_W];
`else
  logic unused_frac;

  assign unused_frac = ^{div_frac, FRAC_W'(DEF_DIV_FRAC)};
  assign carry       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_int_q  <= DIV_W'(DEF_DIV_INT);
      cnt        <= DIV_W'(DEF_DIV_INT - 1);
      os_cnt     <= '0;
      tick_os    <= 1'b0;
      tick_bit   <= 1'b0;
      tick_mid   <= 1'b0;
      cfg_err    <= 1'b0;
`ifdef BAUD_FRAC_EN
      div_frac_q <= FRAC_W'(DEF_DIV_FRAC);
      acc        <= '0;
`endif
    end else begin
      tick_os  <= 1'b0;
      tick_bit <= 1'b0;
      tick_mid <= 1'b0;
      // Strobes win over a coincident terminal count and swallow that tick.
      if (div_load || restart) begin
        if (div_load) begin
          if (div_ok) begin
            div_int_q  <= div_int;
`ifdef BAUD_FRAC_EN
            div_frac_q <= div_frac;
`endif
            cfg_err    <= 1'b0;
          end else begin
            cfg_err    <= 1'b1;
          end
        end
        cnt    <= div_sel - DIV_W'(1);
        os_cnt <= '0;
`ifdef BAUD_FRAC_EN
        acc    <= '0;
`endif
      end else if (en) begin
        if (cnt != '0) begin
          cnt <= cnt - DIV_W'(1);
        end else begin
          tick_os  <= 1'b1;
          tick_bit <= (os_cnt == OS_LAST);
          tick_mid <= (os_cnt == OS_MID);
          // A carry stretches the next interval by one clock.
          cnt      <= div_int_q - DIV_W'(1) + DIV_W'(carry);
          os_cnt   <= os_cnt + OS_W'(1);
`ifdef BAUD_FRAC_EN
          acc      <= acc_sum[FRAC_W-1:0];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: tests push predicted tick times, a monitor pops and compares.
module tb_baud_gen_frac;

  localparam int OS       = 16;
  localparam int FRAC_MOD = 16;
  localparam int DEF_INT  = 13;
  localparam int DEF_FRAC = 9;
`ifdef BAUD_FRAC_EN
  localparam int FRAC_ON = 1;
`else
  localparam int FRAC_ON = 0;
`endif
  localparam int EFF_FRAC = (FRAC_ON != 0) ? DEF_FRAC : 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b1;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        restart = 1'b0;
  logic        tick_os, tick_bit, tick_mid, cfg_err;

  baud_gen_frac dut (
    .clk(clk), .reset(reset), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .restart(restart), .tick_os(tick_os), .tick_bit(tick_bit),
    .tick_mid(tick_mid), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit b;
    bit m;
  } exp_t;

  exp_t q[$];
  int   bit_cycs[$];
  int   checks = 0;
  int   errors = 0;
  int   last_tick = 0;
  bit   mon_on = 1'b0;
  exp_t mon_e;

  // Monitor: every observed tick must match the next predicted one.
  always @(negedge clk) begin
    if (mon_on && reset) begin
      if (tick_os) begin
        last_tick = cyc;
        if (tick_bit) bit_cycs.push_back(cyc);
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick: tick_os at cyc %0d, required none", cyc);
        end else begin
          mon_e = q.pop_front();
          if (cyc !== mon_e.cyc || tick_bit !== mon_e.b || tick_mid !== mon_e.m) begin
            errors++;
            $display("FAIL tick: got cyc=%0d bit=%b mid=%b, required cyc=%0d bit=%b mid=%b",
                     cyc, tick_bit, tick_mid, mon_e.cyc, mon_e.b, mon_e.m);
          end
        end
      end else if (tick_bit || tick_mid) begin
        checks++;
        errors++;
        $display("FAIL stray_tick: bit=%b mid=%b without tick_os at cyc %0d, required 0",
                 tick_bit, tick_mid, cyc);
      end else if (q.size() != 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        mon_e = q.pop_front();
        $display("FAIL missed_tick: no tick_os at cyc %0d, required one (now %0d)", mon_e.cyc, cyc);
      end
    end
  end

  task automatic predict(input int base, input int div, input int frac, input int n);
    int t;
    int a;
    int s;
    t = base + div;
    a = 0;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.cyc = t;
      e.b   = ((k % OS) == OS - 1);
      e.m   = ((k % OS) == OS / 2 - 1);
      q.push_back(e);
      s = a + frac;
      t += div + ((s >= FRAC_MOD) ? 1 : 0);
      a = s % FRAC_MOD;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at a negedge; the strobe is sampled on the next rising edge, returned in e.
  task automatic strobe(input bit ld, input bit rs, input int di, input int df, output int e);
    e        = cyc + 1;
    div_int  = 16'(di);
    div_frac = 4'(df);
    div_load = ld;
    restart  = rs;
    @(negedge clk);
    div_load = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic test_reset;
    int c0;
    reset = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tick_os, tick_bit, tick_mid, cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got %b, required 0000", {tick_os, tick_bit, tick_mid, cfg_err});
    end
    c0    = cyc;
    reset = 1'b1;
    bit_cycs.delete();
    predict(c0, DEF_INT, EFF_FRAC, 32);
    mon_on = 1'b1;
  endtask

  task automatic test_default_rate;
    int d;
    drain(1000);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL default_drain: %0d ticks outstanding, required 0", q.size());
      q.delete();
    end
    d = (bit_cycs.size() >= 2) ? bit_cycs[1] - bit_cycs[0] : -1;
    checks++;
    if (d !== ((FRAC_ON != 0) ? 217 : 208)) begin
      errors++;
      $display("FAIL default_bit_interval: got %0d, required %0d", d, (FRAC_ON != 0) ? 217 : 208);
    end
    mon_on = 1'b0;
  endtask

  task automatic test_restart;
    int e;
    int s;
    int nxt;
    wait_cyc(cyc + 1);
    strobe(1'b0, 1'b1, 0, 0, e);
    predict(e, DEF_INT, EFF_FRAC, 7);
    mon_on = 1'b1;
    drain(300);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL restart_pre: %0d ticks outstanding, required 0", q.size());
      q.delete();
    end
    // os_cnt is now 7; restart 5 cycles into the interval.
    s = last_tick + 5;
    wait_cyc(s - 1);
    strobe(1'b0, 1'b1, 0, 0, e);
    predict(e, DEF_INT, EFF_FRAC, 16);
    drain(400);
    checks++;
    if (q.size() != 0 || e !== s) begin
      errors++;
      $display("FAIL restart_mid: outstanding=%0d strobe_edge=%0d, required 0 and %0d", q.size(), e, s);
      q.delete();
    end
    // Restart landing exactly on a terminal count must swallow that tick.
    nxt = last_tick + DEF_INT + ((((15 * EFF_FRAC) % FRAC_MOD) + EFF_FRAC >= FRAC_MOD) ? 1 : 0);
    wait_cyc(nxt - 1);
    strobe(1'b0, 1'b1, 0, 0, e);
    predict(e, DEF_INT, EFF_FRAC, 2);
    drain(100);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL restart_coincident: %0d ticks outstanding, required 0", q.size());
      q.delete();
    end
    mon_on = 1'b0;
  endtask

  task automatic test_enable;
    int s;
    int gap_bad;
    strobe(1'b0, 1'b1, 0, 0, s);
    predict(s + 20, DEF_INT, EFF_FRAC, 10);
    mon_on = 1'b1;
    wait_cyc(s + 6);
    en      = 1'b0;
    gap_bad = 0;
    while (cyc < s + 26) begin
      @(negedge clk);
      if (tick_os || tick_bit || tick_mid) gap_bad++;
    end
    en = 1'b1;
    checks++;
    if (gap_bad !== 0) begin
      errors++;
      $display("FAIL enable_gap: %0d tick cycles while disabled, required 0", gap_bad);
    end
    drain(300);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL enable_resume: %0d ticks outstanding, required 0", q.size());
      q.delete();
    end
    mon_on = 1'b0;
  endtask

  task automatic test_div_load;
    int e;
    int d;
    strobe(1'b1, 1'b0, 1, 3, e);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL reject_one: cfg_err=%b, required 1", cfg_err);
    end
    predict(e, DEF_INT, EFF_FRAC, 4);
    mon_on = 1'b1;
    drain(200);
    strobe(1'b1, 1'b0, 4, 0, e);
    checks++;
    if (cfg_err !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL accept_four: cfg_err=%b outstanding=%0d, required 0 and 0", cfg_err, q.size());
      q.delete();
    end
    bit_cycs.delete();
    predict(e, 4, 0, 32);
    drain(300);
    d = (bit_cycs.size() >= 2) ? bit_cycs[1] - bit_cycs[0] : -1;
    checks++;
    if (d !== 64 || q.size() != 0) begin
      errors++;
      $display("FAIL div4_bit_interval: got %0d outstanding=%0d, required 64 and 0", d, q.size());
      q.delete();
    end
    strobe(1'b1, 1'b0, 0, 5, e);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL reject_zero: cfg_err=%b, required 1", cfg_err);
    end
    predict(e, 4, 0, 3);
    drain(100);
    strobe(1'b1, 1'b1, 2, 0, e);
    checks++;
    if (cfg_err !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL accept_two: cfg_err=%b outstanding=%0d, required 0 and 0", cfg_err, q.size());
      q.delete();
    end
    predict(e, 2, 0, 20);
    drain(200);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL div2_run: %0d ticks outstanding, required 0", q.size());
      q.delete();
    end
    mon_on = 1'b0;
  endtask

  task automatic test_async_reset;
    int e;
    int c;
    strobe(1'b1, 1'b0, 1, 0, e);
    wait_cyc(e + 2);
    checks++;
    if (tick_os !== 1'b1 || cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: tick_os=%b cfg_err=%b, required 1 1", tick_os, cfg_err);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({tick_os, tick_bit, tick_mid, cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b, required 0000", {tick_os, tick_bit, tick_mid, cfg_err});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({tick_os, tick_bit, tick_mid, cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: got %b, required 0000", {tick_os, tick_bit, tick_mid, cfg_err});
    end
    c     = cyc;
    reset = 1'b1;
    bit_cycs.delete();
    predict(c, DEF_INT, EFF_FRAC, 16);
    mon_on = 1'b1;
    drain(400);
    checks++;
    if (q.size() != 0 || bit_cycs.size() != 1) begin
      errors++;
      $display("FAIL post_reset: outstanding=%0d bits=%0d, required 0 and 1", q.size(), bit_cycs.size());
      q.delete();
    end
    mon_on = 1'b0;
  endtask

  initial begin
    test_reset;
    test_default_rate;
    test_restart;
    test_enable;
    test_div_load;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised successor to the fixed-rate baud tick generator for the UART path.
- Produces an oversampling tick (`tick_os`), a bit-rate tick (`tick_bit`) and a mid-bit sample tick (`tick_mid`).
- Divisor is runtime-programmable, with an integer part plus an optional fractional part.
- `restart` realigns the tick phase to an RX start-bit edge. One instance feeds both the UART TX and RX FSMs.

Parameters:
- DIV_W, 16, width of integer divisor.
- FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W clock).
- OVERSAMPLE, 16, tick_os pulses per bit; power of two, >=4.
- DEF_DIV_INT, 13, integer divisor after reset (25 MHz, 115200 baud, x16).
- DEF_DIV_FRAC, 9, fractional divisor after reset (13 + 9/16 = 13.5625).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- en  in  1  count enable; counters freeze while low.
- div_int  in  DIV_W  integer divisor, sampled on div_load.
- div_frac  in  FRAC_W  fractional divisor, sampled on div_load.
- div_load  in  1  one-cycle strobe: latch divisor and restart phase.
- restart  in  1  one-cycle strobe: realign phase, divisor unchanged.
- tick_os  out  1  one-cycle oversample tick.
- tick_bit  out  1  one-cycle bit tick, coincident with every OVERSAMPLE-th tick_os.
- tick_mid  out  1  one-cycle tick at the bit midpoint.
- cfg_err  out  1  sticky: last div_load was rejected.

Behaviour:
- All outputs are registered.
- Reset (reset=0, async) puts the block in this state:
  - div_int_q=DEF_DIV_INT, div_frac_q=DEF_DIV_FRAC.
  - acc=0, cnt=DEF_DIV_INT-1, os_cnt=0.
  - tick_os/tick_bit/tick_mid/cfg_err=0.
- Period P of each oversample interval is div_int_q, or div_int_q+1 when the fractional accumulator carries.
- Per enabled cycle (en=1, no strobe):
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: tick_os<=1 for the next cycle.
  - Also on cnt==0: {carry,acc}<=acc+div_frac_q (FRAC_W+1-bit add).
  - Also on cnt==0: cnt<=div_int_q-1+carry.
  - Also on cnt==0: os_cnt<=os_cnt+1, wrapping at OVERSAMPLE.
- tick_bit<=1 alongside tick_os when os_cnt==OVERSAMPLE-1 (wrap).
- tick_mid<=1 alongside tick_os when os_cnt==OVERSAMPLE/2-1.
- Latency: with en held 1 from the first edge after reset release, tick_os is first high in the cycle after the DEF_DIV_INT-th rising edge.
- en=0: cnt, acc and os_cnt hold; all ticks 0 next cycle. Resuming continues from the held count with no lost or extra tick.
- restart=1 (synchronous, ignores en):
  - cnt<=div_int_q-1, acc<=0, os_cnt<=0.
  - All ticks 0 next cycle.
  - The next tick_os follows div_int_q enabled cycles later.
- div_load=1, accept case (div_int>=2):
  - div_int_q<=div_int, div_frac_q<=div_frac, cfg_err<=0.
  - Performs the restart action using the new div_int.
- div_load=1, reject case (div_int<2):
  - Divisor registers unchanged, cfg_err<=1.
  - Restart still performed using the old divisor.
- div_load and restart together: div_load semantics apply.
- Strobes take priority over a coincident cnt==0, and that tick is suppressed.
- Integer-only divisor wraps are not allowed; cnt is never loaded from a 0 or 1 divisor.
- acc wraps modulo 2^FRAC_W. Over OVERSAMPLE ticks with OVERSAMPLE=2^FRAC_W, the carries total exactly div_frac_q.
- Asynchronous reset mid-period forces the reset state immediately. No tick is emitted on the release edge.

Optional Feature:
- Macro: BAUD_FRAC_EN.
- Defined: fractional accumulator is present, as described above.
- Undefined:
  - acc and the carry logic are not built; div_frac and DEF_DIV_FRAC are ignored.
  - P=div_int_q always.
  - div_frac_q reads as 0 internally.
  - All other behaviour is identical.

Test Plan:
- Defaults, macro undefined, en=1 after reset -> tick_os every 13 cycles; tick_bit every 208 cycles; tick_mid 8th tick_os of each bit; cfg_err=0.
- Defaults, BAUD_FRAC_EN defined, en=1 -> 16 consecutive tick_os intervals:
  - nine of 14 cycles and seven of 13;
  - tick_bit interval 217 cycles, steady-state, repeating exactly.
- div_load with div_int=1 while running div=13 -> cfg_err=1, tick_os spacing stays 13 after restart. Then div_load div_int=4, div_frac=0 -> cfg_err=0, tick_os every 4 cycles, tick_bit every 64.
- restart asserted 5 cycles into a 13-cycle interval at os_cnt=7 -> no tick that cycle; next tick_os 13 cycles after the strobe; tick_mid on the 8th tick_os after restart; tick_bit on the 16th.
- en dropped for 20 cycles mid-interval (cnt=6) -> no ticks during the gap; after en=1, tick_os exactly 7 enabled cycles later.
- reset driven to 0 asynchronously between edges mid-interval -> all outputs 0 immediately. After release, first tick_os follows 13 edges with the default divisor restored.
